// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_TX_IDLE,
    PS2_TX_INHIBIT,
    PS2_TX_REQ,
    PS2_TX_SHIFT,
    PS2_TX_ACK,
    PS2_TX_FINISH
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  // PS/2 frames carry odd parity: data ones plus this bit is always odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus clock falling-edge detect.
// Flops reset to 1 so an idle (pulled-up) bus never produces a spurious edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall
);

  logic clk_ff1, clk_ff2, clk_prev;
  logic dat_ff1, dat_ff2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_ff1  <= 1'b1;
      clk_ff2  <= 1'b1;
      clk_prev <= 1'b1;
      dat_ff1  <= 1'b1;
      dat_ff2  <= 1'b1;
    end else begin
      clk_ff1  <= ps2_clk_in;
      clk_ff2  <= clk_ff1;
      clk_prev <= clk_ff2;
      dat_ff1  <= ps2_dat_in;
      dat_ff2  <= dat_ff1;
    end
  end

  assign clk_sync = clk_ff2;
  assign dat_sync = dat_ff2;
  assign fall     = clk_prev & ~clk_ff2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 10 bits shifted on
// device clock falls, ACK check. Lines are driven as pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_t state, state_nxt;

  logic          clk_sync, dat_sync, fall;
  logic [9:0]    frame;
  logic [3:0]    edge_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          ack_ok;
  logic          dat_drv;
  logic          timeout;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .fall       (fall)
  );

  // A fall in the same cycle restarts the window rather than expiring it.
  assign timeout = !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PS2_TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PS2_TX_IDLE:    if (tx_start) state_nxt = PS2_TX_INHIBIT;
      PS2_TX_INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nxt = PS2_TX_REQ;
      PS2_TX_REQ:     state_nxt = PS2_TX_SHIFT;
      PS2_TX_SHIFT: begin
        if (fall && edge_cnt == 4'd10) state_nxt = PS2_TX_ACK;
        else if (timeout)              state_nxt = PS2_TX_FINISH;
      end
      PS2_TX_ACK: begin
        if (timeout || (clk_sync && dat_sync)) state_nxt = PS2_TX_FINISH;
      end
      PS2_TX_FINISH:  state_nxt = PS2_TX_IDLE;
      default:        state_nxt = PS2_TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy    = (state != PS2_TX_IDLE);
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    case (state)
      PS2_TX_INHIBIT: ps2_clk_oe = 1'b1;
      PS2_TX_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
      end
      PS2_TX_SHIFT:   ps2_dat_oe = dat_drv;
      PS2_TX_FINISH: begin
        tx_done  = ack_ok;
        tx_error = ~ack_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame    <= '0;
      edge_cnt <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      ack_ok   <= 1'b0;
      dat_drv  <= 1'b0;
    end else begin
      case (state)
        PS2_TX_IDLE: begin
          if (tx_start) begin
            frame    <= {1'b1, odd_parity(tx_data), tx_data};
            edge_cnt <= '0;
            inh_cnt  <= '0;
            ack_ok   <= 1'b0;
          end
        end
        PS2_TX_INHIBIT: inh_cnt <= inh_cnt + IW'(1);
        PS2_TX_REQ: begin
          to_cnt  <= '0;
          dat_drv <= 1'b1;
        end
        PS2_TX_SHIFT: begin
          if (fall) begin
            to_cnt   <= '0;
            edge_cnt <= edge_cnt + 4'd1;
            // Edges 1..10 put the next frame bit on the line; edge 11 is the device ACK.
            if (edge_cnt == 4'd10) begin
              ack_ok <= ~dat_sync;
            end else begin
              dat_drv <= ~frame[0];
              frame   <= {1'b0, frame[9:1]};
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (timeout) ack_ok <= 1'b0;
          end
        end
        PS2_TX_ACK: begin
          if (fall) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (timeout) ack_ok <= 1'b0;
          end
        end
        default: dat_drv <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus model and a device BFM
// that clocks at a 20-cycle period and samples data on its rising clock edges.
module tb_ps2_host_tx;

  localparam int IC = 8;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device side: waits for the host to release the clock, then clocks n_edges falls.
  task automatic device_rx(input int n_edges, input bit ack, output logic [7:0] d,
                           output logic par, output logic stp, output logic st,
                           output int last_fall);
    int w = 0;
    d = 8'h00; par = 1'b0; stp = 1'b0; last_fall = 0;
    while (!(tx_busy && !ps2_clk_oe) && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 200) begin
      failures++;
      $display("FAIL bfm_release_wait: waited %0d cycles, required < 200", w);
    end
    st = ps2_dat_line;
    repeat (5) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (10) @(negedge clk);
      if (e <= 8)       d[e-1] = ps2_dat_line;
      else if (e == 9)  par    = ps2_dat_line;
      else if (e == 10) stp    = ps2_dat_line;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (e < n_edges) begin
        repeat (5) @(negedge clk);
        if (e == 10 && ack) dev_dat_low = 1'b1;
        repeat (5) @(negedge clk);
      end
    end
  endtask

  task automatic wait_end(input int budget, output int at_cyc);
    int w = 0;
    while (!(tx_done || tx_error) && w < budget) begin
      @(negedge clk);
      w++;
    end
    at_cyc = cyc;
    checks++;
    if (w >= budget) begin
      failures++;
      $display("FAIL completion_wait: no tx_done/tx_error within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_held: busy/done/err/clk_oe/dat_oe=%b required 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_idle: busy/done/err/clk_oe/dat_oe=%b required 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_send_ed();
    logic [7:0] d;
    logic par, stp, st;
    int lf, at, inh, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b110) begin
      failures++;
      $display("FAIL start_latency: busy/clk_oe/dat_oe=%b required 110", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 50) begin
      inh++;
      @(negedge clk);
    end
    checks++;
    if (inh !== 8) begin
      failures++;
      $display("FAIL inhibit_len: %0d cycles, required 8", inh);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin
      failures++;
      $display("FAIL req_cycle: clk_oe/dat_oe=%b required 11", {ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b01) begin
      failures++;
      $display("FAIL clk_release: clk_oe/dat_oe=%b required 01", {ps2_clk_oe, ps2_dat_oe});
    end
    device_rx(11, 1'b1, d, par, stp, st, lf);
    checks++;
    if ({st, d, par, stp} !== {1'b0, 8'hED, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ed_frame: start/data/par/stop=%b/%h/%b/%b required 0/ed/1/1", st, d, par, stp);
    end
    wait_end(100, at);
    checks++;
    if ({tx_done, tx_error} !== 2'b10) begin
      failures++;
      $display("FAIL ed_pulse: done/err=%b required 10", {tx_done, tx_error});
    end
    @(negedge clk);
    checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
      failures++;
      $display("FAIL ed_after: busy/clk_oe/dat_oe=%b required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
      failures++;
      $display("FAIL ed_count: done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] vec [2];
    logic       epar [2];
    logic [7:0] d;
    logic par, stp, st;
    int lf, at;
    vec[0] = 8'hFF; epar[0] = 1'b1;
    vec[1] = 8'h00; epar[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(vec[i]);
      device_rx(11, 1'b1, d, par, stp, st, lf);
      checks++;
      if ({d, par, stp} !== {vec[i], epar[i], 1'b1}) begin
        failures++;
        $display("FAIL parity_frame: data/par/stop=%h/%b/%b required %h/%b/1", d, par, stp, vec[i], epar[i]);
      end
      wait_end(100, at);
      checks++;
      if ({tx_done, tx_error} !== 2'b10) begin
        failures++;
        $display("FAIL parity_pulse: done/err=%b required 10", {tx_done, tx_error});
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_nack();
    logic [7:0] d;
    logic par, stp, st;
    int lf, at, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    device_rx(11, 1'b0, d, par, stp, st, lf);
    wait_end(100, at);
    checks++;
    if ({tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 4'b0100) begin
      failures++;
      $display("FAIL nack_pulse: done/err/clk_oe/dat_oe=%b required 0100",
               {tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL nack_count: done=%0d err=%0d busy=%b required 0/1/0", done_cnt - d0, err_cnt - e0, tx_busy);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    logic par, stp, st;
    int lf, at;
    send(8'hED);
    device_rx(4, 1'b1, d, par, stp, st, lf);
    wait_end(200, at);
    // 2 synchronizer flops + edge register, then 64 cycles without a fall.
    checks++;
    if ((at - lf) !== 67) begin
      failures++;
      $display("FAIL timeout_delay: %0d cycles after last fall, required 67", at - lf);
    end
    checks++;
    if ({tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 4'b0100) begin
      failures++;
      $display("FAIL timeout_pulse: done/err/clk_oe/dat_oe=%b required 0100",
               {tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clk);
    checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_after: busy/clk_oe/dat_oe=%b required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] d;
    logic par, stp, st;
    int lf, at, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    repeat (3) @(negedge clk);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    fork
      device_rx(11, 1'b1, d, par, stp, st, lf);
      begin
        repeat (60) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    checks++;
    if ({d, par, stp} !== {8'hED, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ignore_frame: data/par/stop=%h/%b/%b required ed/1/1", d, par, stp);
    end
    wait_end(100, at);
    repeat (20) @(negedge clk);
    checks++;
    if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0 || tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      failures++;
      $display("FAIL ignore_count: done=%0d err=%0d busy=%b clk_oe=%b required 1/0/0/0",
               done_cnt - d0, err_cnt - e0, tx_busy, ps2_clk_oe);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic par, stp, st;
    int lf, at;
    send(8'hED);
    device_rx(5, 1'b1, d, par, stp, st, lf);
    // Bit 4 of 8'hED is 0, so the host is pulling data low here.
    checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b101) begin
      failures++;
      $display("FAIL midframe_pre: busy/clk_oe/dat_oe=%b required 101", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
      failures++;
      $display("FAIL midframe_reset: busy/clk_oe/dat_oe=%b required 000", {tx_busy, ps2_clk_oe, ps2_dat_oe});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send(8'hEE);
    device_rx(11, 1'b1, d, par, stp, st, lf);
    checks++;
    if ({st, d, par, stp} !== {1'b0, 8'hEE, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ee_frame: start/data/par/stop=%b/%h/%b/%b required 0/ee/1/1", st, d, par, stp);
    end
    wait_end(100, at);
    checks++;
    if ({tx_done, tx_error} !== 2'b10) begin
      failures++;
      $display("FAIL ee_pulse: done/err=%b required 10", {tx_done, tx_error});
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL done_err_overlap: %0d cycles with both high, required 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
